// File: rtl/breakout_pkg.sv
// Shared definitions for the breakout brick logic: brick-field geometry,
// damage encoding, controller state encoding, hit result codes and the
// per-brick points helper.
package breakout_pkg;

  localparam int unsigned NUM_BLOCKS  = 20;
  localparam int unsigned NUM_COLS    = 5;
  localparam int unsigned NUM_ROWS    = 4;
  // Rows with index below this need three hits.
  localparam int unsigned STRONG_ROWS = 2;
  localparam int unsigned POINTS_BASE = 10;

  localparam logic [1:0] DMG_DESTROYED = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StInit,
    StHitRd,
    StHitWr
  } state_e;

  typedef enum logic [1:0] {
    ResDamaged   = 2'd0,
    ResDestroyed = 2'd1,
    ResIgnored   = 2'd2
  } hit_result_e;

  function automatic int unsigned brick_row(input logic [5:0] idx);
    return {26'd0, idx} / NUM_COLS;
  endfunction

  // Only meaningful for idx < NUM_BLOCKS; top row is worth the most.
  function automatic logic [15:0] brick_points(input logic [5:0] idx);
    int unsigned row;
    row = brick_row(idx);
    return 16'(POINTS_BASE * (NUM_ROWS - row));
  endfunction

endpackage

// File: rtl/brick_state_ctrl.sv
// Brick state controller: owns the brick damage table, serialises level-init
// sweeps and collision hits into the renderer's brick-state write port, and
// tracks bricks remaining and score.
//
// Ports:
//   CLK_50MH, reset (async, active-low)
//   init_req                      level-init request pulse
//   hit_valid/hit_idx/hit_ready   hit request handshake
//   hit_done/hit_result           one-cycle completion pulse and result code
//   active_write_enable/_position/_data   renderer brick-state write port
//   query_idx/query_state         registered table read-back
//   bricks_left, score, level_clear, busy
module brick_state_ctrl
  import breakout_pkg::*;
(
  input  logic        CLK_50MH,
  input  logic        reset,
  input  logic        init_req,
  input  logic        hit_valid,
  input  logic [5:0]  hit_idx,
  output logic        hit_ready,
  output logic        hit_done,
  output logic [1:0]  hit_result,
  output logic        active_write_enable,
  output logic [5:0]  active_position,
  output logic [1:0]  active_data,
  input  logic [5:0]  query_idx,
  output logic [1:0]  query_state,
  output logic [4:0]  bricks_left,
  output logic [15:0] score,
  output logic        level_clear,
  output logic        busy
);

  localparam logic [4:0] LastPtr = 5'(NUM_BLOCKS - 1);

  state_e      state_q;
  logic [4:0]  ptr_q;
  logic [5:0]  idx_q;
  logic        init_pending_q;
  logic [1:0]  dmg_q [NUM_BLOCKS];
  logic [4:0]  bricks_left_q;
  logic [15:0] score_q;
  logic        we_q;
  logic [5:0]  pos_q;
  logic [1:0]  data_q;
  logic        hit_done_q;
  hit_result_e hit_result_q;
  logic        level_clear_q;
  logic [1:0]  query_q;

  logic        idx_ok;
  logic [1:0]  cur_dmg;
  logic [1:0]  next_dmg;
  logic        hit_ignore;
  logic [1:0]  query_d;

  // Evaluate the captured hit against the table (used in StHitRd).
  always_comb begin
    idx_ok   = idx_q < 6'(NUM_BLOCKS);
    cur_dmg  = DMG_DESTROYED;
    next_dmg = DMG_DESTROYED;
    if (idx_ok) begin
      cur_dmg = dmg_q[idx_q[4:0]];
    end
    if (brick_row(idx_q) < STRONG_ROWS && cur_dmg != DMG_DESTROYED) begin
      next_dmg = cur_dmg + 2'd1;
    end
    hit_ignore = !idx_ok || (cur_dmg == DMG_DESTROYED);
  end

  // Out-of-range queries read as destroyed.
  always_comb begin
    query_d = DMG_DESTROYED;
    if (query_idx < 6'(NUM_BLOCKS)) begin
      query_d = dmg_q[query_idx[4:0]];
    end
  end

  always_ff @(posedge CLK_50MH or negedge reset) begin
    if (!reset) begin
      state_q        <= StIdle;
      ptr_q          <= '0;
      idx_q          <= '0;
      init_pending_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_BLOCKS; i++) begin
        dmg_q[i] <= '0;
      end
      bricks_left_q  <= 5'(NUM_BLOCKS);
      score_q        <= '0;
      we_q           <= 1'b0;
      pos_q          <= '0;
      data_q         <= '0;
      hit_done_q     <= 1'b0;
      hit_result_q   <= ResDamaged;
      level_clear_q  <= 1'b0;
      query_q        <= '0;
    end else begin
      we_q           <= 1'b0;
      hit_done_q     <= 1'b0;
      level_clear_q  <= 1'b0;
      query_q        <= query_d;
      init_pending_q <= init_pending_q | init_req;

      unique case (state_q)
        StIdle: begin
          if (init_pending_q) begin
            // A request arriving this very cycle still queues another sweep.
            init_pending_q <= init_req;
            state_q        <= StInit;
            ptr_q          <= '0;
            we_q           <= 1'b1;
            pos_q          <= '0;
            data_q         <= '0;
          end else if (hit_valid) begin
            state_q <= StHitRd;
            idx_q   <= hit_idx;
          end
        end
        StInit: begin
          // Strobe for ptr_q is on the port this cycle; commit it to the table.
          dmg_q[ptr_q] <= '0;
          if (ptr_q == LastPtr) begin
            state_q       <= StIdle;
            bricks_left_q <= 5'(NUM_BLOCKS);
          end else begin
            ptr_q  <= ptr_q + 5'd1;
            we_q   <= 1'b1;
            pos_q  <= {1'b0, ptr_q + 5'd1};
            data_q <= '0;
          end
        end
        StHitRd: begin
          // Outputs and table update land together in the StHitWr cycle.
          state_q    <= StHitWr;
          hit_done_q <= 1'b1;
          if (hit_ignore) begin
            hit_result_q <= ResIgnored;
          end else begin
            we_q                <= 1'b1;
            pos_q               <= idx_q;
            data_q              <= next_dmg;
            dmg_q[idx_q[4:0]]   <= next_dmg;
            if (next_dmg == DMG_DESTROYED) begin
              hit_result_q <= ResDestroyed;
              score_q      <= score_q + brick_points(idx_q);
              if (bricks_left_q != 5'd0) begin
                bricks_left_q <= bricks_left_q - 5'd1;
              end
              if (bricks_left_q == 5'd1) begin
                level_clear_q <= 1'b1;
              end
            end else begin
              hit_result_q <= ResDamaged;
            end
          end
        end
        StHitWr: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign hit_ready           = (state_q == StIdle) && !init_pending_q;
  assign busy                = (state_q != StIdle);
  assign hit_done            = hit_done_q;
  assign hit_result          = hit_result_q;
  assign active_write_enable = we_q;
  assign active_position     = pos_q;
  assign active_data         = data_q;
  assign query_state         = query_q;
  assign bricks_left         = bricks_left_q;
  assign score               = score_q;
  assign level_clear         = level_clear_q;

endmodule
